inst_fetch: RTL and testbench

- Instruction source for the 8-bit CPU; drives the CPU's 8-bit instruction bus (`iBus`), one instruction per clock.
- A host fills an internal program store through a valid/ready load port. A start pulse then streams the stored instructions to the CPU in order, with stall support and a done pulse.
- Replaces hand-driven instruction sequencing; sits between the host/loader and the CPU's `iBus` input.

---
 rtl/inst_fetch_pkg.sv | 21 ++
 rtl/inst_fetch_if.sv | 28 ++
 rtl/inst_fetch_prog_mem.sv | 26 ++
 rtl/inst_fetch.sv | 148 ++++++++++++++
 tb/tb_inst_fetch.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch block and its CPU-facing users.
// Holds FSM state encoding, default geometry and the CPU opcode field values.
package inst_fetch_pkg;

    localparam int IF_DEPTH = 16;
    localparam int IF_AW    = 4;
    localparam int IF_IW    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Opcode lives in the upper nibble; MOV direction is distinguished by instruction bit 3.
    localparam logic [3:0] OP_MOV      = 4'h0;
    localparam int         MOV_DIR_BIT = 3;
    localparam logic [3:0] OP_LDC      = 4'h1;
    localparam logic [3:0] OP_NOT      = 4'h3;

endpackage

// File: rtl/inst_fetch_if.sv
// Load port, run control and CPU instruction bus of the fetch block.
// master = host/CPU side, slave = the fetch block.
interface inst_fetch_if #(
    parameter int AW = 4,
    parameter int IW = 8
);
    logic          ld_valid;
    logic [IW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          start;
    logic          stall;
    logic [IW-1:0] iBus;
    logic [AW-1:0] pc;
    logic          running;
    logic          done;
    logic [AW:0]   count;

    modport master (
        output ld_valid, ld_data, ld_last, start, stall,
        input  ld_ready, iBus, pc, running, done, count
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, start, stall,
        output ld_ready, iBus, pc, running, done, count
    );
endinterface

// File: rtl/inst_fetch_prog_mem.sv
// Program store: DEPTH x IW, one synchronous write port and one asynchronous read port.
// No reset; validity of contents is tracked by the fetch block's word count.
module prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: loads a program over valid/ready, then streams it onto iBus one word per clock.
// Latency: first instruction 1 clock after start; all outputs registered except ld_ready.
// Backpressure: ld_ready low while running; stall freezes iBus/pc (and delays done).
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int            DEPTH     = IF_DEPTH,
    parameter int            AW        = IF_AW,
    parameter int            IW        = IF_IW,
    parameter logic [IW-1:0] FILL_INST = '0
) (
    input  logic        clk,
    input  logic        rst,
    inst_fetch_if.slave bus
);

    state_e        state_q, state_d;
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] ibus_q, ibus_d;
    logic          done_q, done_d;
    logic          running_q, running_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [AW-1:0] mem_raddr;
    logic [IW-1:0] mem_rdata;
    logic          ld_acc;
    logic          at_last;

    prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (bus.ld_data),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign ld_acc  = bus.ld_valid && (state_q != ST_RUN);
    assign at_last = ({1'b0, pc_q} == (count_q - (AW+1)'(1)));

    // Read address is a pure function of state/pc so the async read never loops back on itself.
    assign mem_raddr = (state_q == ST_RUN) ? (pc_q + AW'(1)) : '0;

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        count_d   = count_q;
        pc_d      = pc_q;
        ibus_d    = ibus_q;
        done_d    = 1'b0;
        running_d = running_q;
        mem_we    = 1'b0;
        mem_waddr = '0;

        case (state_q)
            ST_IDLE: begin
                if (ld_acc) begin
                    // Any word accepted in IDLE opens a fresh program at address 0.
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    wptr_d    = (AW+1)'(1);
                    if (bus.ld_last) begin
                        count_d = (AW+1)'(1);
                    end else begin
                        count_d = '0;
                        state_d = ST_LOAD;
                    end
                end else if (bus.start && (count_q != '0)) begin
                    state_d   = ST_RUN;
                    ibus_d    = mem_rdata;
                    pc_d      = '0;
                    running_d = 1'b1;
                end
            end

            ST_LOAD: begin
                if (ld_acc) begin
                    mem_we    = 1'b1;
                    mem_waddr = wptr_q[AW-1:0];
                    wptr_d    = wptr_q + (AW+1)'(1);
                    if (bus.ld_last) begin
                        count_d = wptr_q + (AW+1)'(1);
                        state_d = ST_IDLE;
                    end else if (wptr_q == (AW+1)'(DEPTH - 1)) begin
                        count_d = (AW+1)'(DEPTH);
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_RUN: begin
                if (!bus.stall) begin
                    if (at_last) begin
                        ibus_d    = FILL_INST;
                        pc_d      = '0;
                        state_d   = ST_IDLE;
                        running_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        pc_d   = pc_q + AW'(1);
                        ibus_d = mem_rdata;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                running_d = 1'b0;
                ibus_d    = FILL_INST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wptr_q    <= '0;
            count_q   <= '0;
            pc_q      <= '0;
            ibus_q    <= FILL_INST;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            pc_q      <= pc_d;
            ibus_q    <= ibus_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    assign bus.ld_ready = (state_q != ST_RUN);
    assign bus.iBus     = ibus_q;
    assign bus.pc       = pc_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a program-level reference model checked every cycle, plus literal
// expectations on loaded counts, streamed sequences and done timing.
module tb_inst_fetch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_if #(.AW(4), .IW(8)) bus ();

    inst_fetch #(
        .DEPTH     (16),
        .AW        (4),
        .IW        (8),
        .FILL_INST (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a program is an array of words plus a length; running walks an index.
    logic [7:0] m_mem [16];
    int         m_cnt     = 0;
    int         m_wp      = 0;
    bit         m_loading = 1'b0;
    bit         m_run     = 1'b0;
    int         m_pc      = 0;
    logic [7:0] m_ibus    = 8'h00;
    bit         m_done    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_wp = 0; m_loading = 0; m_run = 0;
            m_pc = 0; m_ibus = 8'h00; m_done = 0;
        end else begin
            m_done = 0;
            if (m_run) begin
                if (!bus.stall) begin
                    if (m_pc == m_cnt - 1) begin
                        m_run = 0; m_pc = 0; m_ibus = 8'h00; m_done = 1;
                    end else begin
                        m_pc++;
                        m_ibus = m_mem[m_pc];
                    end
                end
            end else if (bus.ld_valid) begin
                if (!m_loading) begin
                    m_wp = 0; m_cnt = 0;
                end
                m_mem[m_wp] = bus.ld_data;
                m_wp++;
                if (bus.ld_last) begin
                    m_cnt = m_wp; m_loading = 0;
                end else if (m_wp == 16) begin
                    m_cnt = 16; m_loading = 0;
                end else begin
                    m_loading = 1;
                end
            end else if (!m_loading && bus.start && m_cnt > 0) begin
                m_run = 1; m_pc = 0; m_ibus = m_mem[0];
            end
        end
        #1;
        chk("cyc_ibus", bus.iBus, m_ibus);
        chk("cyc_pc", bus.pc, m_pc);
        chk("cyc_running", bus.running, m_run);
        chk("cyc_done", bus.done, m_done);
        chk("cyc_count", bus.count, m_cnt);
        chk("cyc_ld_ready", bus.ld_ready, !m_run);
    end

    logic [7:0] pbuf [16];
    logic [7:0] obs [$];
    int         pcs [$];
    int         done_at;

    task automatic set_prog6();
        pbuf[0] = 8'h15; pbuf[1] = 8'h08; pbuf[2] = 8'h00;
        pbuf[3] = 8'h09; pbuf[4] = 8'h31; pbuf[5] = 8'h0A;
    endtask

    task automatic load(input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = pbuf[i];
            bus.ld_last  = use_last && (i == n - 1);
            @(negedge clk);
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    // Pulse start, record iBus/pc each cycle until done; optional stall window.
    task automatic run_collect(input int stall_at, input int stall_len);
        obs.delete();
        pcs.delete();
        done_at = -1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) begin
                done_at = c;
                break;
            end
            obs.push_back(bus.iBus);
            pcs.push_back(int'(bus.pc));
            if (c == stall_at) bus.stall = 1'b1;
            if (c == stall_at + stall_len) bus.stall = 1'b0;
            @(negedge clk);
        end
        bus.stall = 1'b0;
        if (done_at < 0) chk("done_timeout", 0, 1);
    endtask

    logic [7:0] e_st  [8] = '{8'h15, 8'h08, 8'h00, 8'h09, 8'h09, 8'h09, 8'h31, 8'h0A};
    int         e_stp [8] = '{0, 1, 2, 3, 3, 3, 4, 5};
    logic [7:0] e_r3  [3] = '{8'h15, 8'h31, 8'h0A};

    initial begin
        rst = 1'b1;
        bus.ld_valid = 1'b0; bus.ld_data = 8'h00; bus.ld_last = 1'b0;
        bus.start = 1'b0; bus.stall = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ibus", bus.iBus, 8'h00);
        chk("rst_count", bus.count, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_ld_ready", bus.ld_ready, 1);
        rst = 1'b0;

        // start with an empty program is ignored
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        chk("empty_running", bus.running, 0);
        chk("empty_done", bus.done, 0);
        chk("empty_ibus", bus.iBus, 8'h00);
        bus.start = 1'b0;

        // 6-word program, no stall
        set_prog6();
        load(6, 1'b1);
        chk("p6_count", bus.count, 6);
        run_collect(-1, 0);
        chk("p6_done_at", done_at, 6);
        chk("p6_len", obs.size(), 6);
        for (int i = 0; i < 6 && i < obs.size(); i++) begin
            chk("p6_ibus", obs[i], pbuf[i]);
            chk("p6_pc", pcs[i], i);
        end
        chk("p6_fill", bus.iBus, 8'h00);
        chk("p6_run_off", bus.running, 0);
        @(negedge clk);
        chk("p6_done_pulse", bus.done, 0);

        // same program, stalled twice on 09
        run_collect(3, 2);
        chk("st_done_at", done_at, 8);
        chk("st_len", obs.size(), 8);
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            chk("st_ibus", obs[i], e_st[i]);
            chk("st_pc", pcs[i], e_stp[i]);
        end

        // full-depth load without ld_last
        for (int i = 0; i < 16; i++) pbuf[i] = 8'(8'h10 + i);
        load(16, 1'b0);
        chk("p16_count", bus.count, 16);
        chk("p16_ld_ready", bus.ld_ready, 1);
        run_collect(-1, 0);
        chk("p16_len", obs.size(), 16);
        for (int i = 0; i < 16 && i < obs.size(); i++) chk("p16_ibus", obs[i], 8'(8'h10 + i));

        // 17th word opens a new program from address 0
        pbuf[0] = 8'h55; pbuf[1] = 8'h66;
        load(1, 1'b0);
        chk("new_count0", bus.count, 0);
        bus.ld_valid = 1'b1; bus.ld_data = 8'h66; bus.ld_last = 1'b1;
        @(negedge clk);
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        chk("new_count2", bus.count, 2);
        run_collect(-1, 0);
        chk("new_len", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("new_w0", obs[0], 8'h55);
            chk("new_w1", obs[1], 8'h66);
        end

        // load attempts during RUN, then reset while 09 is presented
        set_prog6();
        load(6, 1'b1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_data = 8'hEE;
        for (int c = 0; c < 4; c++) begin
            chk("rl_ld_ready", bus.ld_ready, 0);
            chk("rl_ibus", bus.iBus, pbuf[c]);
            if (c < 3) @(negedge clk);
        end
        bus.ld_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_ibus", bus.iBus, 8'h00);
        chk("mr_pc", bus.pc, 0);
        chk("mr_count", bus.count, 0);
        chk("mr_running", bus.running, 0);

        // 6-word program followed by a shorter reload
        load(6, 1'b1);
        run_collect(-1, 0);
        chk("rel6_done_at", done_at, 6);
        pbuf[0] = 8'h15; pbuf[1] = 8'h31; pbuf[2] = 8'h0A;
        load(3, 1'b1);
        chk("rel3_count", bus.count, 3);
        run_collect(-1, 0);
        chk("rel3_done_at", done_at, 3);
        chk("rel3_len", obs.size(), 3);
        for (int i = 0; i < 3 && i < obs.size(); i++) chk("rel3_ibus", obs[i], e_r3[i]);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
